// File: rtl/skolem_bvslt_neg_checker.sv
// Bit-serial checker for bvslt(x, bvneg(y)) against a generator's claimed result.
// Latency: out_valid rises W+1 cycles after the accepting edge.
// Backpressure: one tuple in flight; in_ready only in IDLE, the verdict is held until out_ready.
module skolem_bvslt_neg_checker #(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     x,
    input  logic [W-1:0]     y,
    input  logic             exp_res,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             res,
    output logic             mismatch,
    output logic [CNT_W-1:0] err_cnt
);

    // The index must reach W: the extra RUN cycle at idx == W registers the verdict.
    localparam int IW = $clog2(W + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state;
    logic [W-1:0]  x_sr;
    logic [W-1:0]  y_sr;
    logic          exp_q;
    logic [IW-1:0] idx;
    logic          seen;   // a lower bit of y was 1, so the remaining bits of -y are inverted
    logic          lt;     // x <s -y judged on the bits processed so far
    logic          n_bit;
    logic          x_bit;
    logic          last_bit;
    logic          hs_done;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign hs_done   = out_valid && out_ready;

    // Two's complement negation, one bit at a time: copy y up to and including
    // its lowest 1, then invert the rest. Wraps naturally for 0 and the most negative value.
    assign x_bit    = x_sr[0];
    assign n_bit    = y_sr[0] ^ seen;
    assign last_bit = (idx == IW'(W - 1));

    // Control FSM and serial compare datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            x_sr     <= '0;
            y_sr     <= '0;
            exp_q    <= 1'b0;
            idx      <= '0;
            seen     <= 1'b0;
            lt       <= 1'b0;
            res      <= 1'b0;
            mismatch <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        x_sr  <= x;
                        y_sr  <= y;
                        exp_q <= exp_res;
                        idx   <= '0;
                        seen  <= 1'b0;
                        lt    <= 1'b0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (idx == IW'(W)) begin
                        res      <= lt;
                        mismatch <= lt ^ exp_q;
                        state    <= S_DONE;
                    end else begin
                        // The highest differing bit decides: unsigned sense below the
                        // sign bit, inverted sense at the sign bit.
                        if (x_bit != n_bit) begin
                            lt <= last_bit ? x_bit : n_bit;
                        end
                        seen <= seen | y_sr[0];
                        x_sr <= {1'b0, x_sr[W-1:1]};
                        y_sr <= {1'b0, y_sr[W-1:1]};
                        idx  <= idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Saturating count of mismatching verdicts, bumped on the output handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (hs_done && mismatch && (err_cnt != {CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule
